// File: rtl/sdram_read_if.sv
// Signal bundle between the SDRAM read engine, the bus arbiter, the SDRAM pins and the read FIFO.
interface sdram_read_if;
  logic        aref_req;
  logic        rd_en;
  logic        rd_trig;
  logic        rd_req;
  logic        flag_rd_end;
  logic [3:0]  rd_cmd;
  logic [12:0] rd_addr;
  logic [15:0] sdram_dq;
  logic        rfifo_wr_en;
  logic [7:0]  rfifo_wr_data;

  modport master (
    input  aref_req, rd_en, rd_trig, sdram_dq,
    output rd_req, flag_rd_end, rd_cmd, rd_addr, rfifo_wr_en, rfifo_wr_data
  );

  modport slave (
    output aref_req, rd_en, rd_trig, sdram_dq,
    input  rd_req, flag_rd_end, rd_cmd, rd_addr, rfifo_wr_en, rfifo_wr_data
  );
endinterface

// File: rtl/sdram_read.sv
// SDRAM read engine: ACTIVE / READ(burst 4) / PRECHARGE-ALL sequencing over a fixed region,
// yielding to auto-refresh at burst boundaries, with a CAS-latency-aligned capture into the read FIFO.
module sdram_read #(
  parameter int BURST_LEN = 4,
  parameter int COL_END   = 3,
  parameter int ROW_END   = 1,
  parameter int CAS_LAT   = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  sdram_read_if.master bus
);

  localparam logic [3:0]  CMD_NOP  = 4'b0111;
  localparam logic [3:0]  CMD_ACT  = 4'b0011;
  localparam logic [3:0]  CMD_READ = 4'b0101;
  localparam logic [3:0]  CMD_PALL = 4'b0010;
  localparam logic [12:0] ADDR_A10 = 13'h0400;

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    REQ    = 5'b00010,
    ACTIVE = 5'b00100,
    READ   = 5'b01000,
    BREAK  = 5'b10000
  } state_t;

  state_t state_c, state_n;

  logic [1:0]       burst_cnt;
  logic [7:0]       col_cnt;
  logic [12:0]      row_cnt;
  logic             flag_rd;
  logic             row_end;
  logic             rd_data_end;
  logic             brk_flag;
  logic             flag_rd_end_q;
  logic [3:0]       rd_cmd_q;
  logic [12:0]      rd_addr_q;
  logic [CAS_LAT:0] valid_sr;
  logic [15:0]      dq_reg;

  logic burst_step, burst_last, col_last, row_last;
  logic refresh_brk, rd_to_pre;

  assign burst_step  = (state_n == READ);
  assign burst_last  = (burst_cnt == 2'(BURST_LEN - 1));
  assign col_last    = (col_cnt == 8'(COL_END - 1));
  assign row_last    = (row_cnt == 13'(ROW_END - 1));
  // Refresh may only cut in on a burst boundary so an issued burst always drains completely.
  assign refresh_brk = bus.aref_req && (burst_cnt == 2'd0) && flag_rd;
  assign rd_to_pre   = refresh_brk || rd_data_end || (row_end && flag_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_c <= IDLE;
    // NOTE: registers take <= so every flop samples pre-edge values regardless of process order.
    else        state_c <= state_n;
  end

  always_comb begin
    // NOTE: default first, so no path through the case leaves state_n unassigned (no latch).
    state_n = state_c;
    case (state_c)
      IDLE:    if (bus.rd_trig) state_n = REQ;
      REQ:     if (bus.rd_en) state_n = ACTIVE;
      ACTIVE:  state_n = READ;
      READ:    if (rd_to_pre) state_n = BREAK;
      BREAK: begin
        if (bus.aref_req && flag_rd) state_n = REQ;
        else if (flag_rd)            state_n = ACTIVE;
        else                         state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt     <= '0;
      col_cnt       <= '0;
      row_cnt       <= '0;
      row_end       <= 1'b0;
      rd_data_end   <= 1'b0;
      flag_rd       <= 1'b0;
      brk_flag      <= 1'b0;
      flag_rd_end_q <= 1'b0;
    end else begin
      if (burst_step) begin
        burst_cnt <= burst_last ? 2'd0 : burst_cnt + 2'd1;
        if (burst_last) begin
          col_cnt <= col_last ? 8'd0 : col_cnt + 8'd1;
          if (col_last) row_cnt <= row_last ? 13'd0 : row_cnt + 13'd1;
        end
      end
      row_end     <= burst_step && burst_last && col_last;
      rd_data_end <= burst_step && burst_last && col_last && row_last;

      if (bus.rd_trig)      flag_rd <= 1'b1;
      else if (rd_data_end) flag_rd <= 1'b0;

      // A row-change break keeps the bus, so only refresh and end-of-data report a release.
      brk_flag      <= (state_n == BREAK) && (refresh_brk || rd_data_end);
      flag_rd_end_q <= brk_flag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cmd_q  <= CMD_NOP;
      rd_addr_q <= ADDR_A10;
    end else begin
      case (state_n)
        ACTIVE: begin
          rd_cmd_q  <= CMD_ACT;
          rd_addr_q <= row_cnt;
        end
        READ: begin
          rd_cmd_q  <= (burst_cnt == 2'd0) ? CMD_READ : CMD_NOP;
          rd_addr_q <= {3'b000, col_cnt, burst_cnt};
        end
        BREAK: begin
          rd_cmd_q  <= CMD_PALL;
          rd_addr_q <= ADDR_A10;
        end
        default: begin
          rd_cmd_q  <= CMD_NOP;
          rd_addr_q <= ADDR_A10;
        end
      endcase
    end
  end

  // Capture runs off the FSM's READ occupancy: one valid bit per word slot, delayed to meet the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_sr <= '0;
      dq_reg   <= '0;
    end else begin
      valid_sr <= {valid_sr[CAS_LAT-1:0], state_c == READ};
      dq_reg   <= bus.sdram_dq;
    end
  end

  assign bus.rd_req        = (state_n == REQ);
  assign bus.flag_rd_end   = flag_rd_end_q;
  assign bus.rd_cmd        = rd_cmd_q;
  assign bus.rd_addr       = rd_addr_q;
  assign bus.rfifo_wr_en   = valid_sr[CAS_LAT];
  assign bus.rfifo_wr_data = dq_reg[7:0];

endmodule

// File: tb/tb_sdram_read.sv
// Bench for sdram_read: two instances (1 row / CL3 and 2 rows / CL2) behind one SDRAM memory model,
// with expected command streams and FIFO contents built from the region-walk rules.
module tb_sdram_read;

  localparam int CL_A = 3, ROW_A = 1, CL_B = 2, ROW_B = 2, COL_END = 3, BL = 4;
  localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD = 4'b0101, C_PALL = 4'b0010;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        aref_req, rd_en, rd_trig, sel;
  logic [15:0] sdram_dq;

  sdram_read_if bus_a ();
  sdram_read_if bus_b ();

  assign bus_a.aref_req = aref_req;  assign bus_b.aref_req = aref_req;
  assign bus_a.rd_en    = rd_en;     assign bus_b.rd_en    = rd_en;
  assign bus_a.rd_trig  = rd_trig;   assign bus_b.rd_trig  = rd_trig;
  assign bus_a.sdram_dq = sdram_dq;  assign bus_b.sdram_dq = sdram_dq;

  sdram_read #(.CAS_LAT(CL_A), .ROW_END(ROW_A)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  sdram_read #(.CAS_LAT(CL_B), .ROW_END(ROW_B)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  logic [3:0]  o_cmd;
  logic [12:0] o_addr;
  logic        o_req, o_end, o_wr;
  logic [7:0]  o_data;
  assign o_cmd  = sel ? bus_b.rd_cmd        : bus_a.rd_cmd;
  assign o_addr = sel ? bus_b.rd_addr       : bus_a.rd_addr;
  assign o_req  = sel ? bus_b.rd_req        : bus_a.rd_req;
  assign o_end  = sel ? bus_b.flag_rd_end   : bus_a.flag_rd_end;
  assign o_wr   = sel ? bus_b.rfifo_wr_en   : bus_a.rfifo_wr_en;
  assign o_data = sel ? bus_b.rfifo_wr_data : bus_a.rfifo_wr_data;

  int errors = 0;
  int checks = 0;

  // SDRAM memory model: opens a row on ACT, returns 4 words CL edges after each READ.
  logic [15:0] mem [0:1][0:15];
  logic [15:0] dq_sched [int];
  int edge_n = 0;
  int open_row = 0;

  function automatic int cur_cl();
    return sel ? CL_B : CL_A;
  endfunction

  always @(posedge clk) begin
    edge_n++;
    if (o_cmd == C_ACT) open_row = int'(o_addr) & 1;
    if (o_cmd == C_RD)
      for (int i = 0; i < BL; i++)
        dq_sched[edge_n + cur_cl() + i] = mem[open_row][(int'(o_addr[7:0]) + i) & 15];
  end

  always @(negedge clk)
    sdram_dq = dq_sched.exists(edge_n + 1) ? dq_sched[edge_n + 1] : 16'($urandom);

  // Observation log, sampled mid-cycle.
  typedef struct { int cyc; logic [3:0] cmd; logic [12:0] addr; } cmd_t;
  cmd_t       cmd_q[$];
  int         wr_cyc_q[$];
  logic [7:0] wr_dat_q[$];
  int         end_q[$];

  always @(negedge clk) begin
    if (o_cmd !== C_NOP) cmd_q.push_back('{edge_n, o_cmd, o_addr});
    if (o_wr === 1'b1) begin
      wr_cyc_q.push_back(edge_n);
      wr_dat_q.push_back(o_data);
    end
    if (o_end === 1'b1) end_q.push_back(edge_n);
  end

  // Reference: the expected command stream and FIFO byte stream of one transfer.
  typedef struct { logic [3:0] cmd; logic [12:0] addr; } exp_cmd_t;
  exp_cmd_t   exp_q[$];
  logic [7:0] exp_words[$];
  int         rd_cyc[$];

  task automatic build_expect(input int rows, input int brk_after);
    int bursts = 0;
    exp_q.delete();
    exp_words.delete();
    for (int r = 0; r < rows; r++) begin
      exp_q.push_back('{C_ACT, 13'(r)});
      for (int b = 0; b < COL_END; b++) begin
        exp_q.push_back('{C_RD, 13'(b * BL)});
        bursts++;
        if (bursts == brk_after && b != COL_END - 1) begin
          exp_q.push_back('{C_PALL, 13'h0400});
          exp_q.push_back('{C_ACT, 13'(r)});
        end
      end
      exp_q.push_back('{C_PALL, 13'h0400});
      for (int c = 0; c < COL_END * BL; c++) exp_words.push_back(mem[r][c][7:0]);
    end
  endtask

  task automatic clear_logs();
    cmd_q.delete(); wr_cyc_q.delete(); wr_dat_q.delete(); end_q.delete(); rd_cyc.delete();
  endtask

  task automatic collect_reads();
    rd_cyc.delete();
    foreach (cmd_q[i]) if (cmd_q[i].cmd == C_RD) rd_cyc.push_back(cmd_q[i].cyc);
  endtask

  task automatic fill_mem(input bit by_index);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 16; c++)
        mem[r][c] = by_index ? {8'($urandom), 8'(c + 16 * r)} : 16'($urandom);
  endtask

  task automatic pulse_trig();
    @(posedge clk); #1 rd_trig = 1'b1;
    @(posedge clk); #1 rd_trig = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (o_cmd !== C_NOP)       begin errors++; $display("FAIL reset_cmd: got %b want %b", o_cmd, C_NOP); end
    checks++; if (o_addr !== 13'h0400)   begin errors++; $display("FAIL reset_addr: got %h want 0400", o_addr); end
    checks++; if (o_wr !== 1'b0 || o_end !== 1'b0 || o_req !== 1'b0)
      begin errors++; $display("FAIL reset_flags: wr=%b end=%b req=%b want 0", o_wr, o_end, o_req); end
    checks++; if (o_data !== 8'h00)      begin errors++; $display("FAIL reset_data: got %h want 00", o_data); end
    @(posedge clk); #1 rst_n = 1'b1;
    wait_cycles(2);
  endtask

  task automatic test_single();
    sel = 1'b0; rd_en = 1'b1; fill_mem(1'b0); clear_logs(); build_expect(ROW_A, -1);
    pulse_trig();
    wait_cycles(50);
    checks++; if (cmd_q.size() != exp_q.size())
      begin errors++; $display("FAIL single_ncmd: got %0d want %0d", cmd_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cmd_q.size(); i++) begin
      checks++;
      if (cmd_q[i].cmd !== exp_q[i].cmd || cmd_q[i].addr !== exp_q[i].addr) begin
        errors++;
        $display("FAIL single_cmd[%0d]: got %b/%h want %b/%h", i, cmd_q[i].cmd, cmd_q[i].addr, exp_q[i].cmd, exp_q[i].addr);
      end
    end
    collect_reads();
    if (rd_cyc.size() == 3 && cmd_q.size() == 5) begin
      checks++; if (rd_cyc[0] != cmd_q[0].cyc + 1)
        begin errors++; $display("FAIL single_act_to_read: got %0d want %0d", rd_cyc[0], cmd_q[0].cyc + 1); end
      checks++; if (rd_cyc[1] - rd_cyc[0] != BL || rd_cyc[2] - rd_cyc[1] != BL)
        begin errors++; $display("FAIL single_read_gap: got %0d,%0d want %0d", rd_cyc[1] - rd_cyc[0], rd_cyc[2] - rd_cyc[1], BL); end
      checks++; if (cmd_q[4].cyc != rd_cyc[2] + BL)
        begin errors++; $display("FAIL single_pall_cycle: got %0d want %0d", cmd_q[4].cyc, rd_cyc[2] + BL); end
      checks++; if (end_q.size() != 1 || end_q[0] != cmd_q[4].cyc + 1)
        begin errors++; $display("FAIL single_end_pulse: got %0d pulses want 1 at %0d", end_q.size(), cmd_q[4].cyc + 1); end
    end
    checks++; if (wr_cyc_q.size() != COL_END * BL * ROW_A)
      begin errors++; $display("FAIL single_nwords: got %0d want %0d", wr_cyc_q.size(), COL_END * BL * ROW_A); end
    checks++; if (o_req !== 1'b0) begin errors++; $display("FAIL single_idle_req: got %b want 0", o_req); end
  endtask

  task automatic test_data_order();
    sel = 1'b0; rd_en = 1'b1; fill_mem(1'b1); clear_logs(); build_expect(ROW_A, -1);
    pulse_trig();
    wait_cycles(7);
    pulse_trig();  // ignored while a transfer is running
    wait_cycles(45);
    checks++; if (wr_dat_q.size() != exp_words.size())
      begin errors++; $display("FAIL order_nwords: got %0d want %0d", wr_dat_q.size(), exp_words.size()); end
    for (int j = 0; j < exp_words.size() && j < wr_dat_q.size(); j++) begin
      checks++; if (wr_dat_q[j] !== exp_words[j])
        begin errors++; $display("FAIL order_data[%0d]: got %h want %h", j, wr_dat_q[j], exp_words[j]); end
    end
    collect_reads();
    if (rd_cyc.size() == COL_END && wr_cyc_q.size() > 0) begin
      checks++; if (wr_cyc_q[0] != rd_cyc[0] + CL_A + 1)
        begin errors++; $display("FAIL order_first_latency: got %0d want %0d", wr_cyc_q[0] - rd_cyc[0], CL_A + 1); end
      for (int j = 0; j < wr_cyc_q.size() && j < COL_END * BL; j++) begin
        checks++; if (wr_cyc_q[j] != rd_cyc[j / BL] + CL_A + 1 + j % BL)
          begin errors++; $display("FAIL order_word_cycle[%0d]: got %0d want %0d", j, wr_cyc_q[j], rd_cyc[j / BL] + CL_A + 1 + j % BL); end
      end
    end
    checks++; if (end_q.size() != 1) begin errors++; $display("FAIL order_end_count: got %0d want 1", end_q.size()); end
  endtask

  task automatic test_refresh();
    int  n_rd;
    bit  seen;
    sel = 1'b0; rd_en = 1'b1; fill_mem(1'b0); clear_logs(); build_expect(ROW_A, 2);
    pulse_trig();
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(posedge clk); #1;
      n_rd = 0;
      foreach (cmd_q[i]) if (cmd_q[i].cmd == C_RD) n_rd++;
      seen = (n_rd >= 2);
    end
    checks++; if (!seen) begin errors++; $display("FAIL refresh_second_read: got timeout want READ"); end
    aref_req = 1'b1; rd_en = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin @(posedge clk); #1; seen = (end_q.size() > 0); end
    checks++; if (!seen) begin errors++; $display("FAIL refresh_end_pulse: got timeout want pulse"); end
    wait_cycles(5);
    @(negedge clk);
    checks++; if (o_req !== 1'b1) begin errors++; $display("FAIL refresh_req_again: got %b want 1", o_req); end
    @(posedge clk); #1 aref_req = 1'b0; rd_en = 1'b1;
    wait_cycles(40);
    checks++; if (cmd_q.size() != exp_q.size())
      begin errors++; $display("FAIL refresh_ncmd: got %0d want %0d", cmd_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cmd_q.size(); i++) begin
      checks++;
      if (cmd_q[i].cmd !== exp_q[i].cmd || cmd_q[i].addr !== exp_q[i].addr) begin
        errors++;
        $display("FAIL refresh_cmd[%0d]: got %b/%h want %b/%h", i, cmd_q[i].cmd, cmd_q[i].addr, exp_q[i].cmd, exp_q[i].addr);
      end
    end
    checks++; if (wr_dat_q.size() != exp_words.size())
      begin errors++; $display("FAIL refresh_nwords: got %0d want %0d", wr_dat_q.size(), exp_words.size()); end
    for (int j = 0; j < exp_words.size() && j < wr_dat_q.size(); j++) begin
      checks++; if (wr_dat_q[j] !== exp_words[j])
        begin errors++; $display("FAIL refresh_data[%0d]: got %h want %h", j, wr_dat_q[j], exp_words[j]); end
    end
    checks++; if (end_q.size() != 2 || (cmd_q.size() > 3 && end_q[0] != cmd_q[3].cyc + 1))
      begin errors++; $display("FAIL refresh_end_count: got %0d pulses want 2, first after the break PALL", end_q.size()); end
  endtask

  task automatic test_rd_en_low();
    int req_hi = 0;
    sel = 1'b0; rd_en = 1'b0; fill_mem(1'b0); clear_logs(); build_expect(ROW_A, -1);
    pulse_trig();
    repeat (10) begin @(negedge clk); if (o_req === 1'b1) req_hi++; end
    checks++; if (req_hi != 10) begin errors++; $display("FAIL stall_req: got %0d cycles want 10", req_hi); end
    checks++; if (cmd_q.size() != 0 || wr_cyc_q.size() != 0)
      begin errors++; $display("FAIL stall_quiet: got %0d cmds %0d writes want 0 0", cmd_q.size(), wr_cyc_q.size()); end
    @(posedge clk); #1 rd_en = 1'b1;
    wait_cycles(50);
    checks++; if (wr_dat_q.size() != exp_words.size() || (wr_dat_q.size() > 0 && wr_dat_q[$] !== exp_words[$]))
      begin errors++; $display("FAIL stall_resume_words: got %0d want %0d", wr_dat_q.size(), exp_words.size()); end
  endtask

  task automatic test_row_change();
    sel = 1'b1; rd_en = 1'b1; fill_mem(1'b1); clear_logs(); build_expect(ROW_B, -1);
    pulse_trig();
    wait_cycles(70);
    checks++; if (cmd_q.size() != exp_q.size())
      begin errors++; $display("FAIL row_ncmd: got %0d want %0d", cmd_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cmd_q.size(); i++) begin
      checks++;
      if (cmd_q[i].cmd !== exp_q[i].cmd || cmd_q[i].addr !== exp_q[i].addr) begin
        errors++;
        $display("FAIL row_cmd[%0d]: got %b/%h want %b/%h", i, cmd_q[i].cmd, cmd_q[i].addr, exp_q[i].cmd, exp_q[i].addr);
      end
    end
    checks++; if (wr_dat_q.size() != exp_words.size())
      begin errors++; $display("FAIL row_nwords: got %0d want %0d", wr_dat_q.size(), exp_words.size()); end
    for (int j = 0; j < exp_words.size() && j < wr_dat_q.size(); j++) begin
      checks++; if (wr_dat_q[j] !== exp_words[j])
        begin errors++; $display("FAIL row_data[%0d]: got %h want %h", j, wr_dat_q[j], exp_words[j]); end
    end
    collect_reads();
    if (rd_cyc.size() == COL_END * ROW_B) begin
      for (int j = 0; j < wr_cyc_q.size() && j < COL_END * BL * ROW_B; j++) begin
        checks++; if (wr_cyc_q[j] != rd_cyc[j / BL] + CL_B + 1 + j % BL)
          begin errors++; $display("FAIL row_word_cycle[%0d]: got %0d want %0d", j, wr_cyc_q[j], rd_cyc[j / BL] + CL_B + 1 + j % BL); end
      end
    end
    checks++; if (end_q.size() != 1 || (cmd_q.size() > 0 && end_q[0] != cmd_q[$].cyc + 1))
      begin errors++; $display("FAIL row_end_pulse: got %0d pulses want 1 after final PALL", end_q.size()); end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    int n_before;
    sel = 1'b0; rd_en = 1'b1; fill_mem(1'b0); clear_logs();
    pulse_trig();
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk); #1;
      foreach (cmd_q[i]) if (cmd_q[i].cmd == C_RD) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rstmid_first_read: got timeout want READ"); end
    wait_cycles(2);
    rst_n = 1'b0;
    #1;
    checks++; if (o_cmd !== C_NOP || o_addr !== 13'h0400)
      begin errors++; $display("FAIL rstmid_cmd: got %b/%h want %b/0400", o_cmd, o_addr, C_NOP); end
    checks++; if (o_wr !== 1'b0 || o_end !== 1'b0 || o_data !== 8'h00)
      begin errors++; $display("FAIL rstmid_outputs: wr=%b end=%b data=%h want 0 0 00", o_wr, o_end, o_data); end
    n_before = cmd_q.size();
    wait_cycles(3);
    @(posedge clk); #1 rst_n = 1'b1;
    wait_cycles(8);
    checks++; if (cmd_q.size() != n_before)
      begin errors++; $display("FAIL rstmid_no_pall: got %0d extra cmds want 0", cmd_q.size() - n_before); end
    clear_logs(); build_expect(ROW_A, -1);
    pulse_trig();
    wait_cycles(50);
    checks++; if (cmd_q.size() != exp_q.size() || (cmd_q.size() > 1 && (cmd_q[0].addr !== 13'h0 || cmd_q[1].addr !== 13'h0)))
      begin errors++; $display("FAIL rstmid_restart_cmds: got %0d cmds want %0d from row0/col0", cmd_q.size(), exp_q.size()); end
    checks++; if (wr_dat_q.size() != exp_words.size() || (wr_dat_q.size() > 0 && wr_dat_q[0] !== exp_words[0]))
      begin errors++; $display("FAIL rstmid_restart_words: got %0d want %0d", wr_dat_q.size(), exp_words.size()); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    sel = 1'b0; aref_req = 1'b0; rd_en = 1'b0; rd_trig = 1'b0; sdram_dq = '0;
    test_reset();
    test_single();
    test_data_order();
    test_refresh();
    test_rd_en_low();
    test_row_change();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
